gbus_initiator: RTL and testbench

- Synthesizable Z80-style bus-cycle initiator for the g-bus (ga/gd/n_gmreq/n_giorq/n_grd/n_gwr/n_gm1). It is the initiator end of the interface that sizif512_ext responds on.
- Takes single transactions over a valid/ready request port and sequences them as T-states derived from clk32.
- Returns read data and a completion strobe.
- Used as the on-card master for self-test, and as a bench driver for sizif512_ext.

---
 rtl/gbus_initiator.sv | 196 +++++++++++++++++++
 tb/tb_gbus_initiator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbus_initiator.sv
// Z80-style g-bus cycle initiator: accepts one request at a time and plays it out
// as T-states built from HALF_T clk32 cycles per half, with n_gwait-driven TW insertion.
module gbus_initiator #(
   parameter int HALF_T = 4
) (
   input  logic        clk32,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_cmd,
   input  logic        req_m1,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [15:0] ga,
   output logic [7:0]  gd_out,
   output logic        gd_oe,
   input  logic [7:0]  gd_in,
   output logic        n_gmreq,
   output logic        n_giorq,
   output logic        n_grd,
   output logic        n_gwr,
   output logic        n_gm1,
   input  logic        n_gwait
);

   localparam int CW = (HALF_T > 1) ? $clog2(HALF_T) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HALF_T - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_TW   = 3'd3;
   localparam logic [2:0] S_T3   = 3'd4;

   localparam logic [1:0] CMD_MRD  = 2'b00;
   localparam logic [1:0] CMD_MWR  = 2'b01;
   localparam logic [1:0] CMD_IORD = 2'b10;
   localparam logic [1:0] CMD_IOWR = 2'b11;

   logic [2:0]    state_r, state_s;
   logic          half_r, half_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [1:0]    cmd_r, cmd_s;
   logic          m1_r, m1_s;
   logic [15:0]   addr_r, addr_s;
   logic [7:0]    wdata_r, wdata_s;
   logic          half_end_s;
   logic          done_s;
   logic          capture_s;
   logic [5:0]    ctl_s;

   // Bus control for a given position: {gd_oe, n_gmreq, n_giorq, n_grd, n_gwr, n_gm1}.
   // TW sits inside every strobe window, so waits never change the strobes.
   function automatic logic [5:0] bus_ctl(input logic [2:0] st, input logic hf,
                                          input logic [1:0] cmd, input logic m1);
      logic in_a;
      logic in_b;
      logic in_c;
      logic oe;
      logic mreq;
      logic iorq;
      logic rd;
      logic wr;
      logic fm1;
      in_a = (st == S_T1 && hf) || st == S_T2 || st == S_TW || (st == S_T3 && !hf);
      in_b = st == S_T2 || st == S_TW || (st == S_T3 && !hf);
      in_c = (st == S_T1 && hf) || st == S_T2 || st == S_TW || st == S_T3;
      oe   = 1'b0;
      mreq = 1'b1;
      iorq = 1'b1;
      rd   = 1'b1;
      wr   = 1'b1;
      fm1  = 1'b1;
      case (cmd)
         CMD_MRD: begin
            mreq = !in_a;
            rd   = !in_a;
            fm1  = !(m1 && (st == S_T1 || in_a));
         end
         CMD_MWR: begin
            mreq = !in_a;
            wr   = !in_b;
            oe   = in_c;
         end
         CMD_IORD: begin
            iorq = !in_b;
            rd   = !in_b;
         end
         CMD_IOWR: begin
            iorq = !in_b;
            wr   = !in_b;
            oe   = in_c;
         end
         default: begin
            oe = 1'b0;
         end
      endcase
      return {oe, mreq, iorq, rd, wr, fm1};
   endfunction

   assign req_ready  = (state_r == S_IDLE);
   assign half_end_s = (cnt_r == CNT_LAST);
   assign done_s     = (state_r == S_T3) && half_r && half_end_s;
   assign capture_s  = (state_r == S_T3) && !half_r && half_end_s && !cmd_r[0];

   // Next position (state, half, cycle count) and request latching.
   always_comb begin
      state_s = state_r;
      half_s  = half_r;
      cnt_s   = cnt_r;
      cmd_s   = cmd_r;
      m1_s    = m1_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      if (state_r == S_IDLE) begin
         if (req_valid) begin
            state_s = S_T1;
            half_s  = 1'b0;
            cnt_s   = {CW{1'b0}};
            cmd_s   = req_cmd;
            m1_s    = req_m1 && (req_cmd == CMD_MRD);
            addr_s  = req_addr;
            wdata_s = req_wdata;
         end else begin
            state_s = S_IDLE;
         end
      end else if (!half_end_s) begin
         cnt_s = cnt_r + CW'(1);
      end else begin
         cnt_s = {CW{1'b0}};
         if (!half_r) begin
            half_s = 1'b1;
         end else begin
            half_s = 1'b0;
            case (state_r)
               S_T1:    state_s = S_T2;
               // io cycles always pass through one TW; mem cycles only on a wait request
               S_T2:    state_s = (cmd_r[1] || !n_gwait) ? S_TW : S_T3;
               S_TW:    state_s = n_gwait ? S_T3 : S_TW;
               S_T3:    state_s = S_IDLE;
               default: state_s = S_IDLE;
            endcase
         end
      end
   end

   assign ctl_s = bus_ctl(state_s, half_s, cmd_s, m1_s);

   // State registers and registered bus outputs, all driven from the next position.
   always_ff @(posedge clk32) begin
      if (rst) begin
         state_r   <= S_IDLE;
         half_r    <= 1'b0;
         cnt_r     <= {CW{1'b0}};
         cmd_r     <= 2'b00;
         m1_r      <= 1'b0;
         addr_r    <= 16'hFFFF;
         wdata_r   <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_rdata <= 8'hFF;
         ga        <= 16'hFFFF;
         gd_out    <= 8'h00;
         gd_oe     <= 1'b0;
         n_gmreq   <= 1'b1;
         n_giorq   <= 1'b1;
         n_grd     <= 1'b1;
         n_gwr     <= 1'b1;
         n_gm1     <= 1'b1;
      end else begin
         state_r   <= state_s;
         half_r    <= half_s;
         cnt_r     <= cnt_s;
         cmd_r     <= cmd_s;
         m1_r      <= m1_s;
         addr_r    <= addr_s;
         wdata_r   <= wdata_s;
         rsp_valid <= done_s;
         if (capture_s) begin
            rsp_rdata <= gd_in;
         end else begin
            rsp_rdata <= rsp_rdata;
         end
         ga        <= (state_s == S_IDLE) ? 16'hFFFF : addr_s;
         gd_out    <= ctl_s[5] ? wdata_s : 8'h00;
         gd_oe     <= ctl_s[5];
         n_gmreq   <= ctl_s[4];
         n_giorq   <= ctl_s[3];
         n_grd     <= ctl_s[2];
         n_gwr     <= ctl_s[1];
         n_gm1     <= ctl_s[0];
      end
   end

endmodule

// File: tb/tb_gbus_initiator.sv
// Bench for gbus_initiator: directed table of transactions plus random traffic
// checked cycle by cycle against a half-T index model of the bus waveform.
`timescale 1ns/1ps
module tb_gbus_initiator;

   localparam int HT = 4;
   localparam logic [23:0] IDLE_VEC = {1'b1, 1'b0, 16'hFFFF, 1'b0, 5'b11111};
   localparam logic [23:0] DONE_VEC = {1'b1, 1'b1, 16'hFFFF, 1'b0, 5'b11111};

   logic        clk32 = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_cmd;
   logic        req_m1;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [15:0] ga;
   logic [7:0]  gd_out;
   logic        gd_oe;
   logic [7:0]  gd_in;
   logic        n_gmreq, n_giorq, n_grd, n_gwr, n_gm1;
   logic        n_gwait;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  exp_rdata;

   gbus_initiator #(.HALF_T(HT)) dut (
      .clk32(clk32), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_m1(req_m1), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ga(ga), .gd_out(gd_out),
      .gd_oe(gd_oe), .gd_in(gd_in), .n_gmreq(n_gmreq), .n_giorq(n_giorq),
      .n_grd(n_grd), .n_gwr(n_gwr), .n_gm1(n_gm1), .n_gwait(n_gwait)
   );

   always #5 clk32 = ~clk32;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] act_vec();
      return {req_ready, rsp_valid, ga, gd_oe, n_gmreq, n_giorq, n_grd, n_gwr, n_gm1};
   endfunction

   // Expected bus state in cycle c (1-based after the accept cycle) from the half-index rules.
   function automatic logic [23:0] exp_vec(input logic [1:0] cmd, input logic m1,
                                           input logic [15:0] addr, input int w, input int c);
      int   e;
      int   sb;
      int   l;
      logic rd;
      logic wr;
      logic oe, mreq, iorq, nrd, nwr, nm1;
      e  = (c - 1) / HT;
      sb = cmd[1] ? 5 : 3;
      if (e <= sb) l = e;
      else if (e < sb + 1 + 2 * w) l = sb;
      else l = e - 2 * w;
      rd = !cmd[0];
      wr = cmd[0];
      if (!cmd[1]) begin
         mreq = !(l >= 1 && l <= 4);
         iorq = 1'b1;
         nrd  = !(rd && l >= 1 && l <= 4);
         nwr  = !(wr && l >= 2 && l <= 4);
         nm1  = !(rd && m1 && l <= 4);
         oe   = wr && l >= 1 && l <= 5;
      end else begin
         mreq = 1'b1;
         iorq = !(l >= 2 && l <= 6);
         nrd  = !(rd && l >= 2 && l <= 6);
         nwr  = !(wr && l >= 2 && l <= 6);
         nm1  = 1'b1;
         oe   = wr && l >= 1 && l <= 7;
      end
      return {1'b0, 1'b0, addr, oe, mreq, iorq, nrd, nwr, nm1};
   endfunction

   task automatic idle_cycles(input int n, input string tag);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk32);
         check($sformatf("%s idle%0d", tag, i), 32'(act_vec()), 32'(IDLE_VEC));
      end
   endtask

   // Entered and left at a negedge; the exit negedge is the rsp_valid cycle, so a
   // following call presents its request back-to-back.
   task automatic txn(input logic [1:0] cmd, input logic m1, input logic [15:0] addr,
                      input logic [7:0] wd, input int w, input logic rnd_gd,
                      input logic [7:0] gd_fix, input string tag,
                      output int lat, output int key_low, output int oe_cnt,
                      output int lead, output int trail);
      int          t;
      int          sb;
      int          ec;
      int          e;
      int          first_low;
      int          last_low;
      logic        is_last;
      logic        eff_m1;
      logic        key;
      logic [23:0] ev;
      logic [23:0] av;
      t  = ((cmd[1] ? 8 : 6) + 2 * w) * HT;
      sb = cmd[1] ? 5 : 3;
      ec = (cmd[1] ? 6 : 4) + 2 * w;
      eff_m1 = m1 && (cmd == 2'b00);
      first_low = 0;
      last_low = 0;
      lat = 0;
      key_low = 0;
      oe_cnt = 0;
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_cmd   = cmd;
      req_m1    = m1;
      req_addr  = addr;
      req_wdata = wd;
      gd_in     = rnd_gd ? 8'($urandom) : gd_fix;
      n_gwait   = 1'($urandom);
      for (int c = 1; c <= t + 1; c++) begin
         @(negedge clk32);
         av = act_vec();
         ev = (c <= t) ? exp_vec(cmd, eff_m1, addr, w, c) : DONE_VEC;
         check($sformatf("%s c%0d bus", tag, c), 32'(av), 32'(ev));
         if (ev[5] && c <= t) check($sformatf("%s c%0d gd_out", tag, c), 32'(gd_out), 32'(wd));
         if (rsp_valid && lat == 0) lat = c;
         if (gd_oe) oe_cnt++;
         if (cmd == 2'b00 && m1) key = n_gm1;
         else if (cmd == 2'b00) key = n_grd;
         else if (cmd == 2'b01) key = n_gwr;
         else key = n_giorq;
         if (!key) key_low++;
         if (av[4:0] != 5'b11111) begin
            if (first_low == 0) first_low = c;
            last_low = c;
         end
         // Inputs for this cycle; request fields are scrambled to prove they were latched.
         req_valid = (c <= t) ? 1'($urandom) : 1'b0;
         req_cmd   = 2'($urandom);
         req_m1    = 1'($urandom);
         req_addr  = 16'($urandom);
         req_wdata = 8'($urandom);
         e = (c - 1) / HT;
         is_last = ((c - 1) % HT) == (HT - 1);
         if (is_last && e >= sb && e <= sb + 2 * w && ((e - sb) % 2) == 0)
            n_gwait = ((e - sb) / 2 == w);
         else
            n_gwait = 1'($urandom);
         gd_in = rnd_gd ? 8'($urandom) : gd_fix;
         if (is_last && e == ec && !cmd[0]) exp_rdata = gd_in;
      end
      check({tag, " rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
      req_valid = 1'b0;
      lead  = (first_low == 0) ? t : first_low - 1;
      trail = t + 1 - last_low;
   endtask

   typedef struct {
      logic [1:0]  cmd;
      logic        m1;
      logic [15:0] addr;
      logic [7:0]  wd;
      int          w;
      logic [7:0]  gd;
      logic        b2b;
      int          lat;
      int          low;
      int          oe;
      logic [7:0]  rdata;
   } vec_t;

   vec_t tv[7];

   initial begin
      int lat, key_low, oe_cnt, lead, trail, prev_trail, gap, w;
      logic [1:0] cmd;

      tv[0] = '{2'b00, 1'b0, 16'h1234, 8'h00, 0, 8'hA5, 1'b0, 25, 16, 0, 8'hA5};
      tv[1] = '{2'b00, 1'b1, 16'h0000, 8'h00, 2, 8'h3E, 1'b0, 41, 36, 0, 8'h3E};
      tv[2] = '{2'b11, 1'b0, 16'h00FE, 8'h07, 0, 8'h55, 1'b0, 33, 20, 28, 8'h3E};
      tv[3] = '{2'b10, 1'b0, 16'h00FE, 8'h00, 0, 8'h3C, 1'b0, 33, 20, 0, 8'h3C};
      tv[4] = '{2'b01, 1'b0, 16'h8000, 8'h5A, 0, 8'hC3, 1'b1, 25, 12, 20, 8'h3C};
      tv[5] = '{2'b01, 1'b0, 16'h8001, 8'hA7, 1, 8'h00, 1'b0, 33, 20, 28, 8'h3C};
      tv[6] = '{2'b10, 1'b0, 16'h0042, 8'h00, 1, 8'h81, 1'b0, 41, 28, 0, 8'h81};

      rst = 1'b1;
      req_valid = 1'b0;
      req_cmd = 2'b00;
      req_m1 = 1'b0;
      req_addr = 16'h0000;
      req_wdata = 8'h00;
      gd_in = 8'h00;
      n_gwait = 1'b1;
      repeat (3) @(posedge clk32);
      @(negedge clk32);
      check("reset bus", 32'(act_vec()), 32'(IDLE_VEC));
      check("reset rdata", 32'(rsp_rdata), 32'h0000_00FF);
      check("reset gd_out", 32'(gd_out), 32'h0);
      rst = 1'b0;
      exp_rdata = 8'hFF;
      idle_cycles(100, "post-reset");
      check("idle rdata", 32'(rsp_rdata), 32'h0000_00FF);

      prev_trail = 0;
      for (int i = 0; i < 7; i++) begin
         if (!tv[i].b2b) idle_cycles(2, $sformatf("tv%0d", i));
         txn(tv[i].cmd, tv[i].m1, tv[i].addr, tv[i].wd, tv[i].w, 1'b0, tv[i].gd,
             $sformatf("tv%0d", i), lat, key_low, oe_cnt, lead, trail);
         check($sformatf("tv%0d latency", i), 32'(lat), 32'(tv[i].lat));
         check($sformatf("tv%0d strobe_low", i), 32'(key_low), 32'(tv[i].low));
         check($sformatf("tv%0d oe_cycles", i), 32'(oe_cnt), 32'(tv[i].oe));
         check($sformatf("tv%0d rdata_tbl", i), 32'(rsp_rdata), 32'(tv[i].rdata));
         if (tv[i].b2b) begin
            gap = prev_trail + lead;
            check($sformatf("tv%0d b2b gap>=5", i), 32'(gap >= 5), 32'd1);
         end
         prev_trail = trail;
      end

      // Reset during T2 of a mem write: bus must drop at the next edge with no response.
      idle_cycles(2, "pre-abort");
      check("abort ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_cmd = 2'b01;
      req_m1 = 1'b0;
      req_addr = 16'h4321;
      req_wdata = 8'h99;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk32);
         req_valid = 1'b0;
         n_gwait = 1'b1;
      end
      check("abort mid n_gwr", 32'(n_gwr), 32'd0);
      rst = 1'b1;
      @(negedge clk32);
      check("abort bus", 32'(act_vec()), 32'(IDLE_VEC));
      check("abort rdata", 32'(rsp_rdata), 32'h0000_00FF);
      rst = 1'b0;
      exp_rdata = 8'hFF;
      idle_cycles(30, "post-abort");
      txn(2'b00, 1'b0, 16'h2468, 8'h00, 0, 1'b0, 8'h6D, "after-abort",
          lat, key_low, oe_cnt, lead, trail);
      check("after-abort latency", 32'(lat), 32'd25);
      check("after-abort rdata_tbl", 32'(rsp_rdata), 32'h0000_006D);

      // Random traffic: random idle gaps (including back-to-back), waits and data.
      for (int i = 0; i < 40; i++) begin
         idle_cycles($urandom_range(0, 3), $sformatf("rnd%0d", i));
         cmd = 2'($urandom);
         w = $urandom_range(0, 3);
         txn(cmd, 1'($urandom), 16'($urandom), 8'($urandom), w, 1'b1, 8'h00,
             $sformatf("rnd%0d", i), lat, key_low, oe_cnt, lead, trail);
         check($sformatf("rnd%0d latency", i), 32'(lat),
               32'(((cmd[1] ? 8 : 6) + 2 * w) * HT + 1));
      end
      idle_cycles(5, "final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
